conv_kernel_1x2_ctrl: RTL and testbench

- Sequencer for the dual-output-channel 3x3 conv kernel (72-bit window, two 72-bit weight sets, two signed 20-bit results).
- For one output pixel it fetches per-input-channel weights from the weight buffer and streams IN_CH windows into the kernel.
- It tracks the kernel's fixed pipeline latency, accumulates both channel results across all IN_CH input channels, and presents the final pair on a valid/ready result port.

---
 rtl/conv_kernel_1x2_ctrl.sv | 156 +++++++++++++++
 tb/tb_conv_kernel_1x2_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kernel_1x2_ctrl.sv
// rtl/conv_kernel_1x2_ctrl.sv - per-pixel sequencer for the dual-output-channel 3x3 conv kernel
// Fetches weights, streams IN_CH windows, tracks kernel latency and accumulates both channels.
module conv_kernel_1x2_ctrl #(
    parameter int IN_CH      = 16,
    parameter int KERNEL_LAT = 4,
    parameter int CH_W       = 20,
    parameter int ACC_W      = 24,
    localparam int ADDR_W    = (IN_CH > 1) ? $clog2(IN_CH) : 1
) (
    input  logic                    sclk,
    input  logic                    s_rst_n,
    input  logic                    start,
    output logic                    busy,
    input  logic                    win_valid,
    output logic                    win_ready,
    input  logic [71:0]             win_data,
    output logic                    wt_rd_en,
    output logic [ADDR_W-1:0]       wt_rd_addr,
    input  logic [71:0]             wt_rd_ch0,
    input  logic [71:0]             wt_rd_ch1,
    output logic [71:0]             k_data_in,
    output logic [71:0]             k_ch0_weight,
    output logic [71:0]             k_ch1_weight,
    input  logic signed [CH_W-1:0]  k_ch0_out,
    input  logic signed [CH_W-1:0]  k_ch1_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [ACC_W-1:0] res_ch0,
    output logic signed [ACC_W-1:0] res_ch1,
    output logic                    done
);

    localparam int CNT_W = $clog2(IN_CH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_CH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;

    state_e                  state_q;
    logic                    busy_q;
    logic                    rd_start_q;
    logic                    wt_avail_q;
    logic                    res_valid_q;
    logic [CNT_W-1:0]        issue_cnt_q;
    logic [CNT_W-1:0]        ret_cnt_q;
    logic [KERNEL_LAT-1:0]   vpipe_q;
    logic [KERNEL_LAT-1:0]   vpipe_d;
    logic [71:0]             k_data_q;
    logic [71:0]             k_w0_q;
    logic [71:0]             k_w1_q;
    logic signed [ACC_W-1:0] acc0_q;
    logic signed [ACC_W-1:0] acc1_q;
    logic signed [ACC_W-1:0] ext0;
    logic signed [ACC_W-1:0] ext1;
    logic                    accept;
    logic                    prefetch;
    logic                    ret;

    // The weights for the next channel are requested in the accept cycle so
    // they are on wt_rd_ch* exactly when the following window can be taken.
    assign win_ready  = wt_avail_q;
    assign accept     = win_valid & wt_avail_q & (state_q == ISSUE);
    assign prefetch   = accept & (issue_cnt_q != LAST_IDX);
    assign wt_rd_en   = rd_start_q | prefetch;
    assign wt_rd_addr = prefetch ? ADDR_W'(issue_cnt_q + CNT_W'(1)) : '0;

    assign ret  = vpipe_q[KERNEL_LAT-1] & ((state_q == ISSUE) | (state_q == DRAIN));
    assign ext0 = ACC_W'($signed(k_ch0_out));
    assign ext1 = ACC_W'($signed(k_ch1_out));

    always_comb begin
        vpipe_d    = vpipe_q << 1;
        vpipe_d[0] = accept;
    end

    assign busy         = busy_q;
    assign k_data_in    = k_data_q;
    assign k_ch0_weight = k_w0_q;
    assign k_ch1_weight = k_w1_q;
    assign res_valid    = res_valid_q;
    assign res_ch0      = acc0_q;
    assign res_ch1      = acc1_q;
    assign done         = res_valid_q & res_ready;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rd_start_q  <= 1'b0;
            wt_avail_q  <= 1'b0;
            res_valid_q <= 1'b0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            vpipe_q     <= '0;
            k_data_q    <= '0;
            k_w0_q      <= '0;
            k_w1_q      <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
        end else begin
            rd_start_q <= 1'b0;
            vpipe_q    <= vpipe_d;

            if (wt_rd_en) begin
                wt_avail_q <= 1'b1;
            end else if (accept) begin
                wt_avail_q <= 1'b0;
            end

            if (accept) begin
                k_data_q    <= win_data;
                k_w0_q      <= wt_rd_ch0;
                k_w1_q      <= wt_rd_ch1;
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end

            // First return of a pixel overwrites, so no explicit clear is needed.
            if (ret) begin
                acc0_q    <= (ret_cnt_q == '0) ? ext0 : acc0_q + ext0;
                acc1_q    <= (ret_cnt_q == '0) ? ext1 : acc1_q + ext1;
                ret_cnt_q <= ret_cnt_q + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= ISSUE;
                        busy_q      <= 1'b1;
                        rd_start_q  <= 1'b1;
                        issue_cnt_q <= '0;
                        ret_cnt_q   <= '0;
                    end
                end
                ISSUE: begin
                    if (accept && (issue_cnt_q == LAST_IDX)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ret && (ret_cnt_q == LAST_IDX)) begin
                        state_q     <= OUT;
                        res_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_kernel_1x2_ctrl.sv
// tb/tb_conv_kernel_1x2_ctrl.sv - self-checking bench for conv_kernel_1x2_ctrl
module tb_conv_kernel_1x2_ctrl;

    localparam int IN_CH = 16;
    localparam int KL    = 4;
    localparam int CH_W  = 20;
    localparam int ACC_W = 24;

    logic sclk = 1'b0;
    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc++;

    logic                    s_rst_n, start, res_ready;
    logic                    win_valid = 1'b0;
    logic [71:0]             win_data  = '0;
    logic                    busy, win_ready, wt_rd_en, res_valid, done;
    logic [3:0]              wt_rd_addr;
    logic [71:0]             wt_rd_ch0 = '0, wt_rd_ch1 = '0;
    logic [71:0]             k_data_in, k_ch0_weight, k_ch1_weight;
    logic signed [CH_W-1:0]  k_ch0_out, k_ch1_out;
    logic signed [ACC_W-1:0] res_ch0, res_ch1;

    logic                    start1, res_ready1;
    logic                    win_valid1;
    logic [71:0]             win_data1;
    logic                    busy1, win_ready1, wt_rd_en1, res_valid1, done1;
    logic [0:0]              wt_rd_addr1;
    logic [71:0]             wt1_ch0 = '0, wt1_ch1 = '0;
    logic [71:0]             k1_data, k1_w0, k1_w1;
    logic signed [CH_W-1:0]  k1_ch0_out, k1_ch1_out;
    logic signed [ACC_W-1:0] r1_ch0, r1_ch1;

    conv_kernel_1x2_ctrl #(.IN_CH(IN_CH), .KERNEL_LAT(KL), .CH_W(CH_W), .ACC_W(ACC_W)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .start(start), .busy(busy),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_ch0(wt_rd_ch0), .wt_rd_ch1(wt_rd_ch1),
        .k_data_in(k_data_in), .k_ch0_weight(k_ch0_weight), .k_ch1_weight(k_ch1_weight),
        .k_ch0_out(k_ch0_out), .k_ch1_out(k_ch1_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch0(res_ch0), .res_ch1(res_ch1),
        .done(done)
    );

    conv_kernel_1x2_ctrl #(.IN_CH(1), .KERNEL_LAT(KL), .CH_W(CH_W), .ACC_W(ACC_W)) dut1 (
        .sclk(sclk), .s_rst_n(s_rst_n), .start(start1), .busy(busy1),
        .win_valid(win_valid1), .win_ready(win_ready1), .win_data(win_data1),
        .wt_rd_en(wt_rd_en1), .wt_rd_addr(wt_rd_addr1), .wt_rd_ch0(wt1_ch0), .wt_rd_ch1(wt1_ch1),
        .k_data_in(k1_data), .k_ch0_weight(k1_w0), .k_ch1_weight(k1_w1),
        .k_ch0_out(k1_ch0_out), .k_ch1_out(k1_ch1_out),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_ch0(r1_ch0), .res_ch1(r1_ch1),
        .done(done1)
    );

    int n_err = 0;
    int n_checks = 0;

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int dot9(input logic [71:0] a, input logic [71:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 9; i++)
            s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
        return s;
    endfunction

    function automatic logic [71:0] rand72();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[71:0];
    endfunction

    // Weight buffers and kernel models (KL-1 pipeline registers after the k_* load)
    logic [71:0] wmem0 [IN_CH];
    logic [71:0] wmem1 [IN_CH];
    logic [71:0] w1a, w1b;
    int kmode = 0;
    int kp0 [KL-1];
    int kp1 [KL-1];
    int k1p0 [KL-1];
    int k1p1 [KL-1];

    always @(posedge sclk) begin
        if (wt_rd_en) begin
            wt_rd_ch0 <= wmem0[wt_rd_addr];
            wt_rd_ch1 <= wmem1[wt_rd_addr];
        end
        if (wt_rd_en1) begin
            wt1_ch0 <= w1a;
            wt1_ch1 <= w1b;
        end
        for (int i = KL-2; i > 0; i--) begin
            kp0[i]  <= kp0[i-1];
            kp1[i]  <= kp1[i-1];
            k1p0[i] <= k1p0[i-1];
            k1p1[i] <= k1p1[i-1];
        end
        kp0[0]  <= dot9(k_data_in, k_ch0_weight);
        kp1[0]  <= dot9(k_data_in, k_ch1_weight);
        k1p0[0] <= dot9(k1_data, k1_w0);
        k1p1[0] <= dot9(k1_data, k1_w1);
    end

    assign k_ch0_out  = (kmode == 1) ? CH_W'(-524288) : CH_W'(kp0[KL-2]);
    assign k_ch1_out  = (kmode == 1) ? CH_W'(524287)  : CH_W'(kp1[KL-2]);
    assign k1_ch0_out = CH_W'(k1p0[KL-2]);
    assign k1_ch1_out = CH_W'(k1p1[KL-2]);

    // Window driver: holds a window until accepted; mode 0 always valid, 1 = 1,0,0 gaps, 2 random
    int drv_en = 0;
    int gap_mode = 0;
    int idle_left = 0;
    logic acc_neg = 1'b0;

    always @(posedge sclk) begin
        #1;
        if (drv_en == 0) begin
            win_valid = 1'b0;
            win_data  = rand72();
            idle_left = 0;
        end else if (!(win_valid && !acc_neg)) begin
            if (win_valid && acc_neg) begin
                win_data = rand72();
                if (gap_mode == 1) idle_left = 2;
            end
            if (idle_left > 0) begin
                win_valid = 1'b0;
                idle_left--;
            end else if (gap_mode == 2) begin
                win_valid = 1'($urandom % 2);
            end else begin
                win_valid = 1'b1;
            end
        end
    end

    // Monitor: records accepted windows and event cycles, checks k_* loads and read addresses
    logic [71:0] wq [$];
    int acc_cnt = 0, rd_cnt = 0;
    int acc_first = -1, acc_last = -1, rd_first = -1, res_cyc = -1, done_cyc = -1;
    int hold_chk = 0, ready_chk = 0;
    logic acc_prev = 1'b0;
    logic [71:0] k_prev = '0;

    always @(negedge sclk) begin
        acc_neg = win_valid && win_ready;
        if (!s_rst_n) begin
            acc_prev = 1'b0;
        end else begin
            if (acc_prev && acc_cnt >= 1 && acc_cnt <= IN_CH) begin
                check_eq("k_data_load", k_data_in, wq[$]);
                check_eq("k_wt0_load", k_ch0_weight, wmem0[acc_cnt-1]);
                check_eq("k_wt1_load", k_ch1_weight, wmem1[acc_cnt-1]);
            end
            if (hold_chk != 0 && !acc_prev && acc_cnt > 0)
                check_eq("k_hold_gap", k_data_in, k_prev);
            if (ready_chk != 0 && acc_cnt >= 1 && acc_cnt < IN_CH)
                check_eq("win_ready_wait", win_ready, 1'b1);
            if (wt_rd_en) begin
                if (rd_cnt == 0) rd_first = cyc;
                check_eq("rd_addr", wt_rd_addr, rd_cnt);
                rd_cnt++;
            end
            if (acc_neg) begin
                wq.push_back(win_data);
                if (acc_cnt == 0) acc_first = cyc;
                acc_last = cyc;
                acc_cnt++;
            end
            if (res_valid && res_cyc < 0) res_cyc = cyc;
            if (done && done_cyc < 0) done_cyc = cyc;
            k_prev   = k_data_in;
            acc_prev = acc_neg;
        end
    end

    int rd1_cnt = 0, acc1_cnt = 0, acc1_cyc = -1, res1_cyc = -1, done1_cnt = 0;
    logic signed [ACC_W-1:0] r1_cap0 = '0, r1_cap1 = '0;

    always @(negedge sclk) begin
        if (s_rst_n) begin
            if (wt_rd_en1) rd1_cnt++;
            if (win_valid1 && win_ready1) begin
                acc1_cnt++;
                acc1_cyc = cyc;
            end
            if (res_valid1 && res1_cyc < 0) begin
                res1_cyc = cyc;
                r1_cap0  = r1_ch0;
                r1_cap1  = r1_ch1;
            end
            if (done1) done1_cnt++;
        end
    end

    int t0 = 0;
    logic signed [ACC_W-1:0] cap0, cap1;

    task automatic begin_pixel(input int gmode, input int km, input int stall);
        @(posedge sclk);
        #2;
        wq.delete();
        acc_cnt = 0; rd_cnt = 0;
        acc_first = -1; acc_last = -1; rd_first = -1; res_cyc = -1; done_cyc = -1;
        for (int i = 0; i < IN_CH; i++) begin
            wmem0[i] = rand72();
            wmem1[i] = rand72();
        end
        gap_mode  = gmode;
        kmode     = km;
        res_ready = (stall == 0);
        drv_en    = 1;
        start     = 1'b1;
        t0        = cyc;
        @(posedge sclk);
        #2 start = 1'b0;
    endtask

    task automatic finish_pixel(input int stall);
        int s0, s1;
        logic signed [ACC_W-1:0] r0, r1, e0, e1;
        for (int i = 0; i < 300; i++) begin
            @(negedge sclk);
            if (res_valid === 1'b1) break;
        end
        check_eq("res_valid_timeout", res_valid, 1'b1);
        r0 = res_ch0;
        r1 = res_ch1;
        for (int s = 1; s < stall; s++) begin
            @(posedge sclk);
            #2 start = 1'(s % 2);
            @(negedge sclk);
            check_eq("stall_valid", res_valid, 1'b1);
            check_eq("stall_ch0", res_ch0, r0);
            check_eq("stall_ch1", res_ch1, r1);
            check_eq("stall_no_done", done, 1'b0);
        end
        if (stall > 0) begin
            @(posedge sclk);
            #2;
            start     = 1'b1;
            res_ready = 1'b1;
            @(negedge sclk);
        end
        check_eq("done_on_handshake", done, 1'b1);
        s0 = 0;
        s1 = 0;
        foreach (wq[k]) begin
            if (kmode == 1) begin
                s0 += -524288;
                s1 += 524287;
            end else if (k < IN_CH) begin
                s0 += dot9(wq[k], wmem0[k]);
                s1 += dot9(wq[k], wmem1[k]);
            end
        end
        e0 = ACC_W'(s0);
        e1 = ACC_W'(s1);
        check_eq("res_ch0", res_ch0, e0);
        check_eq("res_ch1", res_ch1, e1);
        cap0 = res_ch0;
        cap1 = res_ch1;
        @(posedge sclk);
        #2;
        start  = 1'b0;
        drv_en = 0;
        @(negedge sclk);
        check_eq("res_valid_clear", res_valid, 1'b0);
        check_eq("busy_clear", busy, 1'b0);
        check_eq("done_clear", done, 1'b0);
        check_eq("accept_count", acc_cnt, IN_CH);
        check_eq("read_count", rd_cnt, IN_CH);
        @(negedge sclk);
        check_eq("stays_idle", busy, 1'b0);
        check_eq("no_stray_read", wt_rd_en, 1'b0);
    endtask

    initial begin
        int st;
        s_rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
        start1 = 1'b0; win_valid1 = 1'b0; win_data1 = '0; res_ready1 = 1'b1;
        w1a = '0; w1b = '0;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_win_ready", win_ready, 1'b0);
        check_eq("rst_wt_rd_en", wt_rd_en, 1'b0);
        check_eq("rst_wt_rd_addr", wt_rd_addr, 4'd0);
        check_eq("rst_k_data", k_data_in, 72'd0);
        check_eq("rst_k_wt0", k_ch0_weight, 72'd0);
        check_eq("rst_res_valid", res_valid, 1'b0);
        check_eq("rst_res_ch0", res_ch0, 24'd0);
        check_eq("rst_done", done, 1'b0);
        s_rst_n = 1'b1;

        // Full-throughput streaming with cycle-exact timing
        begin_pixel(0, 0, 0);
        finish_pixel(0);
        check_eq("first_read_cycle", rd_first, t0 + 1);
        check_eq("first_accept_cycle", acc_first, t0 + 2);
        check_eq("last_accept_cycle", acc_last, t0 + 17);
        check_eq("res_valid_cycle", res_cyc, t0 + 22);
        check_eq("done_cycle", done_cyc, t0 + 22);

        // Extreme kernel outputs: sign extension and full accumulator range
        begin_pixel(0, 1, 0);
        finish_pixel(0);
        check_eq("sign_ch0", cap0, -8388608);
        check_eq("sign_ch1", cap1, 8388592);

        // Valid gaps 1,0,0
        hold_chk  = 1;
        ready_chk = 1;
        begin_pixel(1, 0, 0);
        finish_pixel(0);
        hold_chk  = 0;
        ready_chk = 0;

        // Result stall with ignored start pulses
        begin_pixel(2, 0, 10);
        finish_pixel(10);

        repeat (3) begin
            st = $urandom_range(0, 3);
            begin_pixel(2, 0, st);
            finish_pixel(st);
        end

        // Asynchronous reset mid-ISSUE
        begin_pixel(0, 0, 0);
        for (int i = 0; i < 50 && acc_cnt < 5; i++) @(negedge sclk);
        check_eq("reach_5_accepts", acc_cnt >= 5, 1'b1);
        #3 s_rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_win_ready", win_ready, 1'b0);
        check_eq("arst_wt_rd_en", wt_rd_en, 1'b0);
        check_eq("arst_wt_rd_addr", wt_rd_addr, 4'd0);
        check_eq("arst_k_data", k_data_in, 72'd0);
        check_eq("arst_k_wt1", k_ch1_weight, 72'd0);
        check_eq("arst_res_ch0", res_ch0, 24'd0);
        check_eq("arst_res_valid", res_valid, 1'b0);
        drv_en = 0;
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        s_rst_n = 1'b1;
        begin_pixel(0, 0, 0);
        finish_pixel(0);
        check_eq("post_rst_first_read", rd_first, t0 + 1);

        // IN_CH=1 variant
        w1a = rand72();
        w1b = rand72();
        @(posedge sclk);
        #2;
        win_data1  = rand72();
        win_valid1 = 1'b1;
        start1     = 1'b1;
        st         = cyc;
        @(posedge sclk);
        #2 start1 = 1'b0;
        repeat (15) @(posedge sclk);
        #2 win_valid1 = 1'b0;
        @(negedge sclk);
        check_eq("ic1_reads", rd1_cnt, 1);
        check_eq("ic1_accepts", acc1_cnt, 1);
        check_eq("ic1_accept_cycle", acc1_cyc, st + 2);
        check_eq("ic1_res_cycle", res1_cyc, acc1_cyc + KL + 1);
        check_eq("ic1_res_ch0", r1_cap0, ACC_W'(dot9(win_data1, w1a)));
        check_eq("ic1_res_ch1", r1_cap1, ACC_W'(dot9(win_data1, w1b)));
        check_eq("ic1_done_count", done1_cnt, 1);
        check_eq("ic1_idle", busy1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
